// File: rtl/step_sequencer.sv
// Stepper coil sequencer: times each step from a ramped period, walks an 8-entry phase
// table in half- or full-step mode, and stops cleanly at a step boundary.
module step_sequencer #(
    parameter logic [23:0] START_PERIOD = 24'h16e360,
    parameter logic [23:0] RAMP_STEP    = 24'h00c350,
    parameter logic [23:0] MIN_PERIOD   = 24'd2,
    parameter logic        HOLD_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        direction,
    input  logic        stepSizeKey,
    input  logic [23:0] maxCount,
    output logic [3:0]  coils,
    output logic        stepPulse,
    output logic        busy,
    output logic [23:0] curPeriod,
    output logic        dbg_state_o
);

    typedef enum logic { ST_IDLE = 1'b0, ST_RUN = 1'b1 } state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] period_q, period_d;
    logic [3:0]  coils_q, coils_d;
    logic        pulse_q, pulse_d;

    logic [23:0] tgt;
    logic [23:0] start_period;
    logic [23:0] ramp_period;
    logic        boundary;
    logic [2:0]  phase_inc;
    logic [2:0]  phase_next;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign tgt          = (maxCount < MIN_PERIOD) ? MIN_PERIOD : maxCount;
    assign start_period = (tgt > START_PERIOD) ? tgt : START_PERIOD;
    assign boundary     = (state_q == ST_RUN) && (cnt_q == period_q - 24'd1);

    // Full-step from an odd (two-coil) index skips the single-coil state in between;
    // from an even index a single move realigns onto a two-coil state.
    assign phase_inc  = (stepSizeKey && phase_q[0]) ? 3'd2 : 3'd1;
    assign phase_next = direction ? phase_q + phase_inc : phase_q - phase_inc;

    // Acceleration is rate limited; deceleration takes effect at once.
    always_comb begin
        ramp_period = tgt;
        if (tgt < period_q) begin
            ramp_period = ((period_q - tgt) > RAMP_STEP) ? (period_q - RAMP_STEP) : tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN:  if (boundary && !enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        period_d = period_q;
        coils_d  = coils_q;
        pulse_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = 24'd0;
            if (enable) period_d = start_period;
        end else if (boundary) begin
            cnt_d = 24'd0;
            if (enable) begin
                pulse_d  = 1'b1;
                phase_d  = phase_next;
                coils_d  = phase_pattern(phase_next);
                period_d = ramp_period;
            end
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 24'd0;
            phase_q  <= 3'd0;
            period_q <= START_PERIOD;
            coils_q  <= 4'b0000;
            pulse_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            coils_q  <= coils_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        busy        = (state_q == ST_RUN);
        coils       = (state_q == ST_IDLE && !HOLD_EN) ? 4'b0000 : coils_q;
        stepPulse   = pulse_q;
        curPeriod   = period_q;
        dbg_state_o = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed step table, hand-written stop/reset sequences,
// then randomized inputs against a countdown-based reference model.
module tb_step_sequencer;
  localparam logic [23:0] SP = 24'd20;
  localparam logic [23:0] RS = 24'd4;
  localparam logic [23:0] MP = 24'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        direction;
  logic        stepSizeKey;
  logic [23:0] maxCount;
  logic [3:0]  coils;
  logic        stepPulse;
  logic        busy;
  logic [23:0] curPeriod;
  logic        dbg_state;

  step_sequencer #(
    .START_PERIOD(SP),
    .RAMP_STEP(RS),
    .MIN_PERIOD(MP),
    .HOLD_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .direction(direction),
    .stepSizeKey(stepSizeKey),
    .maxCount(maxCount),
    .coils(coils),
    .stepPulse(stepPulse),
    .busy(busy),
    .curPeriod(curPeriod),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] phase_tab [8];

  typedef struct {
    logic        en;
    logic        dir;
    logic        full;
    logic [23:0] mc;
    int          gap;
    logic [3:0]  exp_coils;
    logic [23:0] exp_period;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts negedges until stepPulse is seen, bounded by limit.
  task automatic wait_pulse(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (stepPulse !== 1'b1 && gap < limit);
    if (stepPulse !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout: no stepPulse within %0d cycles", limit);
      gap = -1;
    end
  endtask

  // reference model: a countdown to the next step boundary
  int         m_run;
  int         m_left;
  int         m_period;
  int         m_phase;
  int         m_pulse;
  logic [3:0] m_coils;

  task automatic model_reset();
    m_run = 0; m_left = 0; m_period = SP; m_phase = 0; m_pulse = 0; m_coils = 4'b0000;
  endtask

  task automatic model_edge();
    int tgt;
    int d;
    tgt = (int'(maxCount) < int'(MP)) ? int'(MP) : int'(maxCount);
    if (rst) begin
      model_reset();
    end else if (m_run == 0) begin
      m_pulse = 0;
      if (enable) begin
        m_run = 1;
        m_period = (tgt > int'(SP)) ? tgt : int'(SP);
        m_left = m_period;
      end
    end else begin
      m_pulse = 0;
      m_left--;
      if (m_left == 0) begin
        if (enable) begin
          m_pulse = 1;
          d = (stepSizeKey && (m_phase % 2 == 1)) ? 2 : 1;
          m_phase = direction ? (m_phase + d) % 8 : (m_phase + 8 - d) % 8;
          m_coils = phase_tab[m_phase];
          if (tgt < m_period) m_period = (m_period - tgt > int'(RS)) ? m_period - int'(RS) : tgt;
          else m_period = tgt;
          m_left = m_period;
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  initial begin
    int gap;
    int pulses;

    phase_tab = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // first entry leaves IDLE, so its gap includes the cycle spent entering RUN
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 24'd8,  21, 4'b1100, 24'd16};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 24'd8,  16, 4'b0100, 24'd12};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 24'd8,  12, 4'b0110, 24'd8};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 24'd8,   8, 4'b0010, 24'd8};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 24'd8,   8, 4'b0011, 24'd8};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 24'd8,   8, 4'b1001, 24'd8};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 24'd8,   8, 4'b1100, 24'd8};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 24'd8,   8, 4'b0110, 24'd8};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 24'd8,   8, 4'b1100, 24'd8};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 24'd8,   8, 4'b1001, 24'd8};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 24'd8,   8, 4'b0011, 24'd8};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 24'd30,  8, 4'b1001, 24'd30};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 24'd0,  30, 4'b1000, 24'd26};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 24'd0,  26, 4'b1001, 24'd22};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 24'd0,  22, 4'b0001, 24'd18};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 24'd0,  18, 4'b0011, 24'd14};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 24'd1,  14, 4'b0010, 24'd10};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 24'd0,  10, 4'b0110, 24'd6};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 24'd0,   6, 4'b0100, 24'd2};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 24'd0,   2, 4'b1100, 24'd2};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 24'd16,  2, 4'b1000, 24'd16};

    rst = 1'b1; enable = 1'b0; direction = 1'b1; stepSizeKey = 1'b0; maxCount = 24'd8;
    repeat (3) @(negedge clk);
    check("reset_coils", 32'(coils), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_pulse", 32'(stepPulse), 32'h0);
    check("reset_period", 32'(curPeriod), 32'(SP));
    rst = 1'b0;

    // idle with enable low
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stepPulse === 1'b1) pulses++;
    end
    check("idle_pulses", 32'(pulses), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_coils", 32'(coils), 32'h0);

    // step table
    for (int i = 0; i < 21; i++) begin
      enable = vecs[i].en; direction = vecs[i].dir;
      stepSizeKey = vecs[i].full; maxCount = vecs[i].mc;
      wait_pulse(200, gap);
      check($sformatf("vec%0d_gap", i), 32'(gap), 32'(vecs[i].gap));
      check($sformatf("vec%0d_coils", i), 32'(coils), 32'(vecs[i].exp_coils));
      check($sformatf("vec%0d_period", i), 32'(curPeriod), 32'(vecs[i].exp_period));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h1);
    end

    // enable drops mid-period: finish the period without stepping, then idle holding coils
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_busy_mid", 32'(busy), 32'h1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stepPulse === 1'b1) pulses++;
    end
    check("stop_pulses", 32'(pulses), 32'h0);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_coils_hold", 32'(coils), 32'b1000);
    check("stop_period", 32'(curPeriod), 32'd16);

    // full step from phase 0, then async reset mid-period and restart
    enable = 1'b1; direction = 1'b1; stepSizeKey = 1'b1; maxCount = 24'd8;
    wait_pulse(200, gap);
    check("full0_gap", 32'(gap), 32'd21);
    check("full0_coils", 32'(coils), 32'b1100);
    check("full0_period", 32'(curPeriod), 32'd16);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_coils", 32'(coils), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_period", 32'(curPeriod), 32'(SP));
    check("rst_pulse", 32'(stepPulse), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_pulse(200, gap);
    check("restart_gap", 32'(gap), 32'd21);
    check("restart_coils", 32'(coils), 32'b1100);
    wait_pulse(200, gap);
    check("restart_gap2", 32'(gap), 32'd16);
    check("restart_coils2", 32'(coils), 32'b0110);
    check("restart_period2", 32'(curPeriod), 32'd12);

    // randomized run against the reference model
    rst = 1'b1; enable = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("rnd_coils", 32'(coils), 32'(m_coils));
      check("rnd_pulse", 32'(stepPulse), 32'(m_pulse));
      check("rnd_busy", 32'(busy), 32'(m_run));
      check("rnd_period", 32'(curPeriod), 32'(m_period));
      check("rnd_state", 32'(dbg_state), 32'(m_run));
      enable = ($urandom_range(0, 9) != 0);
      direction = 1'($urandom_range(0, 1));
      stepSizeKey = 1'($urandom_range(0, 1));
      maxCount = 24'($urandom_range(0, 40));
      rst = ($urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
